quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Decodes a two-phase quadrature signal pair (A/B) from an incremental encoder into single-cycle step/direction pulses.
- Maintains a wrapping position count, with synchronous load, driven from those pulses.
- Sits at the pin boundary and feeds the up/down counting logic: step maps to counter_on and dir maps to count_up.
- Provides input synchronisation, glitch filtering and illegal-transition detection.

Parameters:
- WIDTH, 3, width of the position count and load value.
- SYNC_STAGES, 2, flip-flop stages on each of a_in and b_in (minimum 2).
- FILT, 2, consecutive cycles a new synchronised A/B value must be stable before it is accepted (minimum 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a_in  input  1  raw encoder phase A (asynchronous to clk)
- b_in  input  1  raw encoder phase B (asynchronous to clk)
- enable  input  1  high: steps are emitted and position counts
- load  input  1  synchronous load of position from load_val
- load_val  input  WIDTH  value loaded into position
- err_clr  input  1  clears the sticky err flag
- step  output  1  one-cycle pulse per accepted legal transition
- dir  output  1  direction of the last step (1 = up, A leads B)
- position  output  WIDTH  current position count
- err  output  1  sticky illegal-transition flag

Behaviour:
- Reset values (asynchronous, all registers): sync chains 0, filter candidate 0, filter counter 0, filtered state 2'b00, primed 0, step 0, dir 0, position 0, err 0.
- Synchronisation: a_in and b_in each pass through SYNC_STAGES flops. The result is the 2-bit sync value s = {A,B}.
- Glitch filter:
  - If s equals the filtered state, the filter counter clears.
  - Else if s equals the candidate, the counter increments.
  - Else the candidate loads s and the counter is set to 1.
  - When the counter reaches FILT, the filtered state loads the candidate and the counter clears.
  - Pulses shorter than FILT cycles are never accepted.
- Priming: the first filtered-state update after reset only sets primed=1. It emits no step and no err. If s is already 00 after reset, primed sets once s has been 00 for FILT cycles.
- Decode, on each filtered-state update while primed=1:
  - Up sequence is 00→01→11→10→00. Any single-bit change along it gives step=1, dir=1.
  - The reverse order gives step=1, dir=0.
  - A two-bit change (00↔11, 01↔10) is illegal: err←1, no step, dir unchanged, filtered state still updates.
- Timing: step is registered, high for exactly one cycle. Its latency, counted from the first clk edge that samples the new a_in/b_in level, is SYNC_STAGES+FILT edges. With defaults, step is high in the cycle after edge 4.
- enable=0:
  - Filter, priming and err detection continue.
  - step is forced 0.
  - dir is not updated.
  - position holds.
- position:
  - load=1: position←load_val, regardless of enable or step in the same cycle (load has priority).
  - Else if step is being generated this cycle: +1 if up, −1 if down, modulo 2^WIDTH.
  - Wrap-around: max→0 going up, 0→max going down. No saturation, no flag.
  - The position update is in the same edge that asserts step. Position reflects the step on the cycle step is high.
- err:
  - Sticky until err_clr=1.
  - If err_clr and a new illegal transition occur in the same cycle, err stays 1 (set wins).
- Reset mid-operation: all state returns to reset values asynchronously. The next accepted input is treated as priming, so no spurious step is emitted.
- Inputs held constant produce no steps. Rate limit: at most one step per FILT cycles. Faster input is undersampled and may be reported as illegal.

Test Plan:
- Reset, then hold A=B=0 for 10 cycles, then drive the up sequence 01,11,10,00, each held 8 cycles. Expect primed with no step, then 4 step pulses each one cycle wide, dir=1, position 0→1→2→3→4, err=0.
- load=1, load_val=3'd7, then one up transition. Expect position=7 after the load, then one step with position wrapping to 0. Next, one down transition: position wraps back to 7, dir=0.
- Inject a 1-cycle high glitch on a_in with FILT=2. Expect no step, position unchanged, err=0. A 2-cycle stable change must produce exactly one step, 4 edges after the first sampling edge.
- Filtered state 00, then A and B switch together to 11 and hold. Expect err=1, no step, position unchanged. Pulse err_clr for one cycle: err=0. Err_clr in the same cycle as a new illegal transition: err stays 1.
- enable=0 during 3 up transitions. Expect step=0 and position held. Set enable=1 and apply 1 down transition: step=1, dir=0, position−1, with no burst of missed steps.
- Assert reset asynchronously mid-sequence while inputs=11, then release. Expect all outputs 0 immediately. The first accepted value (11) primes with no step and no err. The following transition 11→10 gives step with dir=1.

Source files
------------

// File: rtl/quad_decoder_if.sv
// Bundle of the encoder pins, control inputs and decoded outputs of quad_decoder.
// master drives the encoder/control side, slave is the decoder itself.
interface quad_decoder_if #(
    parameter int WIDTH = 3
) ();
    logic             a_in;
    logic             b_in;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             err_clr;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] position;
    logic             err;

    modport master (
        output a_in, b_in, enable, load, load_val, err_clr,
        input  step, dir, position, err
    );

    modport slave (
        input  a_in, b_in, enable, load, load_val, err_clr,
        output step, dir, position, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature (A/B) decoder: synchroniser, glitch filter, priming, step/dir
// decode with illegal-transition detection, and a wrapping position counter.
module quad_decoder #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 2
) (
    input  logic          clk,
    input  logic          reset,
    quad_decoder_if.slave bus
);
    localparam int CW = $clog2(FILT + 1);

    logic [SYNC_STAGES-1:0] a_sync_reg;
    logic [SYNC_STAGES-1:0] b_sync_reg;
    // Marks which sync stages hold real samples rather than reset values, so
    // the flushed zeros after reset are never mistaken for an encoder state.
    logic [SYNC_STAGES-1:0] vld_reg;

    logic [1:0]       s;
    logic             s_valid;
    logic [1:0]       cand_reg;
    logic [1:0]       cand_next;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic [1:0]       filt_reg;
    logic             primed_reg;
    logic             accept;
    logic             illegal;
    logic             is_up;
    logic             step_next;
    logic             step_reg;
    logic             dir_reg;
    logic             err_reg;
    logic [WIDTH-1:0] position_reg;

    // Synchronise the raw encoder phases and track when the chain is filled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_reg <= '0;
            b_sync_reg <= '0;
            vld_reg    <= '0;
        end else begin
            a_sync_reg <= {a_sync_reg[SYNC_STAGES-2:0], bus.a_in};
            b_sync_reg <= {b_sync_reg[SYNC_STAGES-2:0], bus.b_in};
            vld_reg    <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s       = {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};
    assign s_valid = vld_reg[SYNC_STAGES-1];

    // Glitch filter: a new value must persist FILT samples before acceptance.
    // Before priming there is no trusted filtered state, so any value
    // (including 00) simply has to be stable for FILT samples.
    always_comb begin
        cand_next = cand_reg;
        cnt_next  = cnt_reg;
        accept    = 1'b0;
        if (s_valid) begin
            if (primed_reg && (s == filt_reg)) begin
                cnt_next = '0;
            end else if (s == cand_reg) begin
                cnt_next = cnt_reg + 1'b1;
            end else begin
                cand_next = s;
                cnt_next  = CW'(1);
            end
            if (cnt_next == CW'(FILT)) begin
                accept   = 1'b1;
                cnt_next = '0;
            end
        end
    end

    // Classify the accepted transition relative to the current filtered state.
    // Going up, each state's successor is {old[0], ~old[1]}: 00->01->11->10->00.
    always_comb begin
        illegal   = &(cand_next ^ filt_reg);
        is_up     = (cand_next == {filt_reg[0], ~filt_reg[1]});
        step_next = accept && primed_reg && !illegal && bus.enable;
    end

    // Filter state, candidate, counter and priming flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_reg   <= 2'b00;
            cnt_reg    <= '0;
            filt_reg   <= 2'b00;
            primed_reg <= 1'b0;
        end else begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_next;
            if (accept) begin
                filt_reg   <= cand_next;
                primed_reg <= 1'b1;
            end
        end
    end

    // Registered step/dir pulse and sticky error; a new illegal transition
    // beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_reg <= 1'b0;
            dir_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            step_reg <= step_next;
            if (step_next) begin
                dir_reg <= is_up;
            end
            if (accept && primed_reg && illegal) begin
                err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Position counter: load has priority, otherwise wraps with each step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position_reg <= '0;
        end else if (bus.load) begin
            position_reg <= bus.load_val;
        end else if (step_next) begin
            if (is_up) begin
                position_reg <= position_reg + 1'b1;
            end else begin
                position_reg <= position_reg - 1'b1;
            end
        end
    end

    assign bus.step     = step_reg;
    assign bus.dir      = dir_reg;
    assign bus.position = position_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// run-length based behavioural model.
module tb_quad_decoder;
    localparam int WIDTH = 3;
    localparam int SYNC  = 2;
    localparam int FILT  = 2;
    localparam int MOD   = 1 << WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC),
        .FILT(FILT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int dut_steps = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Gray order of the up direction; position in this list is the phase index.
    int up_seq[4] = '{0, 1, 3, 2};

    function automatic int ord(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (up_seq[i] == v) r = i;
        end
        return r;
    endfunction

    // What the DUT saw at each rising edge.
    logic       smp_rst = 1'b1;
    logic [1:0] smp_raw = 2'b00;
    logic       smp_en = 1'b0;
    logic       smp_load = 1'b0;
    logic [WIDTH-1:0] smp_lv = '0;
    logic       smp_clr = 1'b0;

    always @(posedge clk) begin
        smp_rst  <= reset;
        smp_raw  <= {bus.a_in, bus.b_in};
        smp_en   <= bus.enable;
        smp_load <= bus.load;
        smp_lv   <= bus.load_val;
        smp_clr  <= bus.err_clr;
    end

    // Behavioural model state.
    int m_k;
    int m_hist[$];
    int m_run;
    int m_last;
    bit m_primed;
    int m_filt;
    bit m_step;
    bit m_dir;
    bit m_err;
    int m_pos;

    task automatic model_reset();
        m_k = 0;
        m_hist.delete();
        m_run = 0;
        m_last = 0;
        m_primed = 0;
        m_filt = 0;
        m_step = 0;
        m_dir = 0;
        m_err = 0;
        m_pos = 0;
    endtask

    // One clock edge of the model: the value seen SYNC edges ago is accepted
    // once it has been seen FILT times in a row and differs from the filtered state.
    task automatic model_edge();
        int s;
        int d;
        bit upd;
        bit ill;
        s = 0;
        d = 0;
        upd = 0;
        ill = 0;
        m_k++;
        if (m_k > SYNC) begin
            s = m_hist[SYNC-1];
            if (m_run > 0 && s == m_last) begin
                m_run++;
            end else begin
                m_last = s;
                m_run = 1;
            end
            if (m_run == FILT && (!m_primed || s != m_filt)) upd = 1;
        end
        m_hist.push_front(int'(smp_raw));
        if (m_hist.size() > SYNC) void'(m_hist.pop_back());
        m_step = 0;
        if (upd) begin
            if (m_primed) begin
                d = (ord(s) - ord(m_filt) + 4) % 4;
                if (d == 2) begin
                    ill = 1;
                end else if (smp_en) begin
                    m_step = 1;
                    m_dir = (d == 1);
                end
            end
            m_primed = 1;
            m_filt = s;
        end
        if (ill) m_err = 1;
        else if (smp_clr) m_err = 0;
        if (smp_load) m_pos = int'(smp_lv);
        else if (m_step) m_pos = m_dir ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
    endtask

    // Compare process: advance the model and check every output each cycle.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset || smp_rst) begin
                model_reset();
            end else begin
                model_edge();
                chk("step", int'(bus.step), int'(m_step));
                chk("dir", int'(bus.dir), int'(m_dir));
                chk("position", int'(bus.position), m_pos);
                chk("err", int'(bus.err), int'(m_err));
                if (bus.step) dut_steps++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        bus.a_in = a;
        bus.b_in = b;
        tick(n);
    endtask

    int s0;
    int lat;
    logic [1:0] cur;
    int act;
    int len;

    initial begin
        reset = 1'b1;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        bus.enable = 1'b1;
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.err_clr = 1'b0;
        tick(3);
        chk("reset_step", int'(bus.step), 0);
        chk("reset_dir", int'(bus.dir), 0);
        chk("reset_position", int'(bus.position), 0);
        chk("reset_err", int'(bus.err), 0);
        reset = 1'b0;

        // Priming on 00, then a full up cycle.
        s0 = dut_steps;
        hold(0, 0, 10);
        chk("prime_no_step", dut_steps - s0, 0);
        hold(0, 1, 8);
        hold(1, 1, 8);
        hold(1, 0, 8);
        hold(0, 0, 8);
        chk("up_cycle_steps", dut_steps - s0, 4);
        chk("up_cycle_position", int'(bus.position), 4);
        chk("up_cycle_dir", int'(bus.dir), 1);
        chk("up_cycle_err", int'(bus.err), 0);

        // Load and wrap in both directions.
        bus.load = 1'b1;
        bus.load_val = 3'd7;
        tick(1);
        bus.load = 1'b0;
        chk("load_position", int'(bus.position), 7);
        hold(0, 1, 8);
        chk("wrap_up_position", int'(bus.position), 0);
        hold(0, 0, 8);
        chk("wrap_down_position", int'(bus.position), 7);
        chk("wrap_down_dir", int'(bus.dir), 0);

        // A one-cycle glitch is rejected; a stable change steps after 4 edges.
        s0 = dut_steps;
        hold(1, 0, 1);
        hold(0, 0, 8);
        chk("glitch_no_step", dut_steps - s0, 0);
        chk("glitch_position", int'(bus.position), 7);
        chk("glitch_err", int'(bus.err), 0);
        bus.a_in = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.step) break;
        end
        chk("step_latency", lat, 4);
        tick(6);
        chk("latency_position", int'(bus.position), 6);

        // Illegal two-bit change, clear, then clear colliding with a new error.
        hold(0, 0, 8);
        s0 = dut_steps;
        hold(1, 1, 8);
        chk("illegal_err", int'(bus.err), 1);
        chk("illegal_no_step", dut_steps - s0, 0);
        chk("illegal_position", int'(bus.position), 7);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("err_clr", int'(bus.err), 0);
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        tick(3);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        tick(4);
        chk("err_set_wins", int'(bus.err), 1);

        // Disabled transitions are tracked but not counted.
        s0 = dut_steps;
        bus.enable = 1'b0;
        hold(0, 1, 8);
        hold(1, 1, 8);
        hold(1, 0, 8);
        chk("disabled_no_step", dut_steps - s0, 0);
        chk("disabled_position", int'(bus.position), 7);
        bus.enable = 1'b1;
        hold(1, 1, 8);
        chk("enable_one_step", dut_steps - s0, 1);
        chk("enable_position", int'(bus.position), 6);
        chk("enable_dir", int'(bus.dir), 0);

        // Asynchronous reset mid-operation with inputs at 11.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_step", int'(bus.step), 0);
        chk("async_reset_position", int'(bus.position), 0);
        chk("async_reset_err", int'(bus.err), 0);
        chk("async_reset_dir", int'(bus.dir), 0);
        tick(2);
        reset = 1'b0;
        s0 = dut_steps;
        tick(10);
        chk("reprime_no_step", dut_steps - s0, 0);
        chk("reprime_err", int'(bus.err), 0);
        hold(1, 0, 8);
        chk("after_reset_step", dut_steps - s0, 1);
        chk("after_reset_dir", int'(bus.dir), 1);
        chk("after_reset_position", int'(bus.position), 1);

        // Randomized walk checked only by the per-cycle model comparison.
        cur = 2'b10;
        for (int it = 0; it < 400; it++) begin
            act = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 6));
            bus.enable = ($urandom_range(0, 4) != 0);
            bus.load = ($urandom_range(0, 19) == 0);
            bus.load_val = WIDTH'($urandom);
            bus.err_clr = ($urandom_range(0, 9) == 0);
            if (act <= 3) cur = 2'(up_seq[(ord(int'(cur)) + 1) % 4]);
            else if (act <= 6) cur = 2'(up_seq[(ord(int'(cur)) + 3) % 4]);
            else if (act == 7) cur = cur ^ 2'b11;
            if (act == 8) begin
                bus.a_in = ~cur[1];
                bus.b_in = cur[0];
            end else begin
                bus.a_in = cur[1];
                bus.b_in = cur[0];
            end
            tick(1);
            bus.load = 1'b0;
            bus.err_clr = 1'b0;
            bus.a_in = cur[1];
            bus.b_in = cur[0];
            if (len > 1) tick(len - 1);
        end
        bus.enable = 1'b1;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
